// File: rtl/cpu19_core.sv
// cpu19_core: single-cycle 19-bit processor with register file, ALU, data RAM,
// call/return stack, XOR-rotate crypto unit and 2-point butterfly; decode exported.
module cpu19_core #(
    parameter int unsigned IMEM_DEPTH = 2048,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter string       IMEM_FILE  = "program.mem"
) (
    input  logic        clk,
    input  logic        reset,
    output logic [18:0] instruction_out,
    output logic [3:0]  opcode_out,
    output logic [3:0]  rd_out,
    output logic [3:0]  rs1_out,
    output logic [3:0]  rs2_out,
    output logic [2:0]  alu_op_out,
    output logic [2:0]  alu_type_out,
    output logic [10:0] jump_addr_out,
    output logic [7:0]  branch_addr_out,
    output logic [18:0] readdata1_out,
    output logic [18:0] readdata2_out,
    output logic [18:0] result_out,
    output logic [18:0] mem_data_out,
    output logic [18:0] write_data_out,
    output logic [18:0] pc_out,
    output logic [18:0] pc_next_out,
    output logic [3:0]  sp_out,
    output logic        encr_en_out,
    output logic        decr_en_out,
    output logic [18:0] encr_result_out,
    output logic        fft_en_out,
    output logic [18:0] fft_result_out
);
    typedef enum logic [3:0] {
        OP_ARITH = 4'b0000, OP_LOGIC, OP_LD,  OP_ST,  OP_JMP, OP_BZ,   OP_BNZ,  OP_CALL,
        OP_RET,             OP_ENC,   OP_DEC, OP_FFT, OP_LI,  OP_NOP0, OP_NOP1, OP_HALT
    } opcode_t;

    logic [18:0] r_imem  [IMEM_DEPTH];
    logic [18:0] r_dmem  [DMEM_DEPTH];
    logic [18:0] r_regs  [16];
    logic [18:0] r_stack [15];
    logic [18:0] r_pc;
    logic [3:0]  r_sp;
    logic        r_zero;

    opcode_t     w_op;
    logic [18:0] w_instr, w_a, w_b, w_rdval, w_alu, w_enc, w_dec, w_x, w_fft, w_mem;
    logic [18:0] w_pc_inc, w_pc_next, w_wd;
    logic [3:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_aop, w_alu_type;
    logic [4:0]  w_shamt;
    logic        w_we, w_zero_we, w_push, w_pop, w_st;

    assign w_instr  = r_imem[r_pc[10:0]];
    assign w_op     = opcode_t'(w_instr[18:15]);
    assign w_rd     = w_instr[14:11];
    assign w_rs1    = w_instr[10:7];
    assign w_rs2    = w_instr[6:3];
    assign w_aop    = w_instr[2:0];
    assign w_a      = r_regs[w_rs1];
    assign w_b      = r_regs[w_rs2];
    assign w_rdval  = r_regs[w_rd];
    assign w_shamt  = w_b[4:0];
    assign w_mem    = r_dmem[w_instr[7:0]];
    assign w_pc_inc = r_pc + 19'd1;

    // ENC rotates left after the XOR; DEC rotates right before it, so DEC undoes ENC.
    assign w_x   = w_a ^ w_b;
    assign w_enc = {w_x[15:0], w_x[18:16]};
    assign w_dec = {w_a[2:0], w_a[18:3]} ^ w_b;
    assign w_fft = w_aop[0] ? (w_a - w_b) : (w_a + w_b);

    always_comb begin
        w_alu = '0;
        if (w_op == OP_ARITH) begin
            case (w_aop)
                3'd0:    w_alu = w_a + w_b;
                3'd1:    w_alu = w_a - w_b;
                3'd2:    w_alu = w_a * w_b;
                3'd3:    w_alu = (w_b == '0) ? '1 : w_a / w_b;
                3'd4:    w_alu = w_a + 19'd1;
                3'd5:    w_alu = w_a - 19'd1;
                3'd6:    w_alu = {18'b0, (w_a < w_b)};
                default: w_alu = w_a;
            endcase
        end else if (w_op == OP_LOGIC) begin
            case (w_aop)
                3'd0:    w_alu = w_a & w_b;
                3'd1:    w_alu = w_a | w_b;
                3'd2:    w_alu = w_a ^ w_b;
                3'd3:    w_alu = ~w_a;
                3'd4:    w_alu = (w_shamt >= 5'd19) ? '0 : (w_a << w_shamt);
                3'd5:    w_alu = (w_shamt >= 5'd19) ? '0 : (w_a >> w_shamt);
                3'd6:    w_alu = ~(w_a & w_b);
                default: w_alu = ~(w_a | w_b);
            endcase
        end
    end

    always_comb begin
        w_pc_next  = w_pc_inc;
        w_we       = 1'b0;
        w_wd       = '0;
        w_zero_we  = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_st       = 1'b0;
        w_alu_type = 3'b111;
        unique case (w_op)
            OP_ARITH, OP_LOGIC: begin
                w_we       = 1'b1;
                w_wd       = w_alu;
                w_zero_we  = 1'b1;
                w_alu_type = (w_op == OP_ARITH) ? 3'b000 : 3'b001;
            end
            OP_LD: begin
                w_we       = 1'b1;
                w_wd       = w_mem;
                w_alu_type = 3'b010;
            end
            OP_ST: begin
                w_st       = 1'b1;
                w_alu_type = 3'b010;
            end
            OP_JMP: begin
                w_pc_next  = {8'b0, w_instr[10:0]};
                w_alu_type = 3'b011;
            end
            OP_BZ, OP_BNZ: begin
                if (r_zero == (w_op == OP_BZ)) w_pc_next = {11'b0, w_instr[7:0]};
                w_alu_type = 3'b011;
            end
            OP_CALL: begin
                if (r_sp != 4'd15) begin
                    w_push    = 1'b1;
                    w_pc_next = {8'b0, w_instr[10:0]};
                end
                w_alu_type = 3'b011;
            end
            OP_RET: begin
                if (r_sp != 4'd0) begin
                    w_pop     = 1'b1;
                    w_pc_next = r_stack[r_sp - 4'd1];
                end
                w_alu_type = 3'b011;
            end
            OP_ENC, OP_DEC: begin
                w_we       = 1'b1;
                w_wd       = (w_op == OP_ENC) ? w_enc : w_dec;
                w_alu_type = 3'b100;
            end
            OP_FFT: begin
                w_we       = 1'b1;
                w_wd       = w_fft;
                w_alu_type = 3'b101;
            end
            OP_LI: begin
                w_we = 1'b1;
                w_wd = {8'b0, w_instr[10:0]};
            end
            OP_HALT: w_pc_next = r_pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc   <= '0;
            r_sp   <= '0;
            r_zero <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) r_regs[i] <= '0;
            for (int unsigned i = 0; i < 15; i++) r_stack[i] <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_we) r_regs[w_rd] <= w_wd;
            if (w_zero_we) r_zero <= (w_alu == '0);
            if (w_push) begin
                r_stack[r_sp] <= w_pc_inc;
                r_sp          <= r_sp + 4'd1;
            end else if (w_pop) begin
                r_sp <= r_sp - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_st) r_dmem[w_instr[7:0]] <= w_rdval;
    end

    assign instruction_out = w_instr;
    assign opcode_out      = w_instr[18:15];
    assign rd_out          = w_rd;
    assign rs1_out         = w_rs1;
    assign rs2_out         = w_rs2;
    assign alu_op_out      = w_aop;
    assign alu_type_out    = w_alu_type;
    assign jump_addr_out   = w_instr[10:0];
    assign branch_addr_out = w_instr[7:0];
    assign readdata1_out   = w_a;
    assign readdata2_out   = w_b;
    assign result_out      = w_alu;
    assign mem_data_out    = w_mem;
    assign write_data_out  = w_wd;
    assign pc_out          = r_pc;
    assign pc_next_out     = w_pc_next;
    assign sp_out          = r_sp;
    assign encr_en_out     = (w_op == OP_ENC);
    assign decr_en_out     = (w_op == OP_DEC);
    assign encr_result_out = (w_op == OP_DEC) ? w_dec : w_enc;
    assign fft_en_out      = (w_op == OP_FFT);
    assign fft_result_out  = w_fft;
endmodule

// File: tb/tb_cpu19_core.sv
// Bench for cpu19_core: instruction-set reference model compared every cycle,
// plus hand-derived literals for the headline program results.
module tb_cpu19_core;
    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [18:0] instruction_out, readdata1_out, readdata2_out, result_out, mem_data_out;
    logic [18:0] write_data_out, pc_out, pc_next_out, encr_result_out, fft_result_out;
    logic [3:0]  opcode_out, rd_out, rs1_out, rs2_out, sp_out;
    logic [2:0]  alu_op_out, alu_type_out;
    logic [10:0] jump_addr_out;
    logic [7:0]  branch_addr_out;
    logic        encr_en_out, decr_en_out, fft_en_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu19_core #(.IMEM_DEPTH(2048), .DMEM_DEPTH(256), .IMEM_FILE("")) dut (
        .clk(clk), .reset(reset), .instruction_out(instruction_out), .opcode_out(opcode_out),
        .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out), .alu_op_out(alu_op_out),
        .alu_type_out(alu_type_out), .jump_addr_out(jump_addr_out),
        .branch_addr_out(branch_addr_out), .readdata1_out(readdata1_out),
        .readdata2_out(readdata2_out), .result_out(result_out), .mem_data_out(mem_data_out),
        .write_data_out(write_data_out), .pc_out(pc_out), .pc_next_out(pc_next_out),
        .sp_out(sp_out), .encr_en_out(encr_en_out), .decr_en_out(decr_en_out),
        .encr_result_out(encr_result_out), .fft_en_out(fft_en_out),
        .fft_result_out(fft_result_out)
    );

    // Reference machine state
    logic [18:0] m_prog [2048];
    logic [18:0] m_r    [16];
    logic [18:0] m_dmem [256];
    bit          m_dv   [256];
    logic [18:0] m_stk  [$];
    logic [18:0] m_pc;
    bit          m_z;

    // Expected values for the current cycle
    logic [18:0] e_ins, e_a, e_b, e_res, e_wd, e_npc, e_crypto, e_fft;
    logic [3:0]  e_op, e_rd, e_rs1, e_rs2;
    logic [2:0]  e_aop, e_type;
    bit          e_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (pc=%0d)", name, act, exp, m_pc);
        end
    endtask

    function automatic logic [18:0] rr(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] s1, input logic [3:0] s2,
                                       input logic [2:0] aop);
        return {op, rd, s1, s2, aop};
    endfunction

    function automatic logic [18:0] ri(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [10:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic load_program;
        for (int i = 0; i < 2048; i++) m_prog[i] = ri(4'hD, 4'd0, 11'd0);
        m_prog[0]  = ri(4'hC, 4'd1, 11'd5);            // LI R1,5
        m_prog[1]  = ri(4'hC, 4'd2, 11'd3);            // LI R2,3
        m_prog[2]  = rr(4'h0, 4'd3, 4'd1, 4'd2, 3'd0); // ADD R3
        m_prog[3]  = rr(4'h0, 4'd4, 4'd2, 4'd2, 3'd1); // SUB R4
        m_prog[4]  = ri(4'h5, 4'd0, 11'h020);          // BZ 0x20
        m_prog[5]  = rr(4'h0, 4'd3, 4'd1, 4'd7, 3'd2); // MUL
        m_prog[6]  = rr(4'h0, 4'd4, 4'd2, 4'd1, 3'd6); // SLT
        m_prog[7]  = ri(4'h7, 4'd0, 11'h040);          // CALL 0x40
        m_prog[8]  = ri(4'h8, 4'd0, 11'd0);            // RET on empty
        m_prog[9]  = ri(4'hC, 4'd2, 11'd19);
        m_prog[10] = rr(4'h1, 4'd15, 4'd7, 4'd2, 3'd5); // SHR by 19
        m_prog[11] = ri(4'h6, 4'd0, 11'h030);          // BNZ not taken
        m_prog[12] = rr(4'h1, 4'd15, 4'd0, 4'd0, 3'd7); // NOR
        m_prog[13] = ri(4'h6, 4'd0, 11'h030);          // BNZ taken
        m_prog[32] = rr(4'hB, 4'd5, 4'd1, 4'd2, 3'd0);
        m_prog[33] = rr(4'hB, 4'd6, 4'd1, 4'd2, 3'd1);
        m_prog[34] = ri(4'hC, 4'd7, 11'h155);
        m_prog[35] = ri(4'hC, 4'd8, 11'h0F0);
        m_prog[36] = rr(4'h9, 4'd9, 4'd7, 4'd8, 3'd0);
        m_prog[37] = rr(4'hA, 4'd10, 4'd9, 4'd8, 3'd0);
        m_prog[38] = ri(4'hC, 4'd13, 11'd1);
        m_prog[39] = rr(4'hB, 4'd12, 4'd0, 4'd13, 3'd1);
        m_prog[40] = ri(4'h3, 4'd1, 11'h010);          // ST R1 -> 0x10
        m_prog[41] = ri(4'h2, 4'd5, 11'h010);          // LD R5 <- 0x10
        m_prog[42] = rr(4'h0, 4'd14, 4'd1, 4'd0, 3'd3); // DIV by zero
        m_prog[43] = ri(4'h4, 4'd0, 11'd5);            // JMP 5
        m_prog[48] = ri(4'h7, 4'd0, 11'd48);           // CALL self until stack full
        m_prog[49] = ri(4'h8, 4'd0, 11'd0);            // RET until empty
        m_prog[50] = ri(4'h7, 4'd0, 11'd60);
        m_prog[60] = ri(4'hF, 4'd0, 11'd0);            // HALT
        m_prog[64] = rr(4'h1, 4'd15, 4'd7, 4'd2, 3'd4); // SHL
        m_prog[65] = ri(4'h8, 4'd0, 11'd0);
        for (int i = 0; i < 2048; i++) dut.r_imem[i] = m_prog[i];
        for (int i = 0; i < 256; i++) m_dv[i] = 1'b0;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_stk.delete();
        m_pc = '0;
        m_z  = 1'b0;
    endtask

    task automatic model_eval;
        logic [18:0] x;
        int unsigned sh;
        e_ins = m_prog[m_pc[10:0]];
        e_op  = e_ins[18:15];
        e_rd  = e_ins[14:11];
        e_rs1 = e_ins[10:7];
        e_rs2 = e_ins[6:3];
        e_aop = e_ins[2:0];
        e_a   = m_r[e_rs1];
        e_b   = m_r[e_rs2];
        sh    = int'(e_b[4:0]);
        e_res = '0;
        if (e_op == 4'h0) begin
            case (e_aop)
                3'd0: e_res = e_a + e_b;
                3'd1: e_res = e_a - e_b;
                3'd2: e_res = e_a * e_b;
                3'd3: e_res = (e_b == 0) ? 19'h7FFFF : e_a / e_b;
                3'd4: e_res = e_a + 1;
                3'd5: e_res = e_a - 1;
                3'd6: e_res = (e_a < e_b) ? 19'd1 : 19'd0;
                default: e_res = e_a;
            endcase
        end else if (e_op == 4'h1) begin
            case (e_aop)
                3'd0: e_res = e_a & e_b;
                3'd1: e_res = e_a | e_b;
                3'd2: e_res = e_a ^ e_b;
                3'd3: e_res = ~e_a;
                3'd4: e_res = (sh >= 19) ? 19'd0 : e_a << sh;
                3'd5: e_res = (sh >= 19) ? 19'd0 : e_a >> sh;
                3'd6: e_res = ~(e_a & e_b);
                default: e_res = ~(e_a | e_b);
            endcase
        end
        x        = e_a ^ e_b;
        e_crypto = (e_op == 4'hA) ? (((e_a >> 3) | (e_a << 16)) ^ e_b) : ((x << 3) | (x >> 16));
        e_fft    = e_aop[0] ? e_a - e_b : e_a + e_b;
        e_we     = 1'b1;
        case (e_op)
            4'h0, 4'h1: e_wd = e_res;
            4'h2:       e_wd = m_dmem[e_ins[7:0]];
            4'h9, 4'hA: e_wd = e_crypto;
            4'hB:       e_wd = e_fft;
            4'hC:       e_wd = {8'b0, e_ins[10:0]};
            default: begin e_wd = '0; e_we = 1'b0; end
        endcase
        e_npc = m_pc + 1;
        case (e_op)
            4'h4: e_npc = {8'b0, e_ins[10:0]};
            4'h5: if (m_z)  e_npc = {11'b0, e_ins[7:0]};
            4'h6: if (!m_z) e_npc = {11'b0, e_ins[7:0]};
            4'h7: if (m_stk.size() < 15) e_npc = {8'b0, e_ins[10:0]};
            4'h8: if (m_stk.size() > 0) e_npc = m_stk[$];
            4'hF: e_npc = m_pc;
            default: ;
        endcase
        case (e_op)
            4'h0: e_type = 3'b000;
            4'h1: e_type = 3'b001;
            4'h2, 4'h3: e_type = 3'b010;
            4'h4, 4'h5, 4'h6, 4'h7, 4'h8: e_type = 3'b011;
            4'h9, 4'hA: e_type = 3'b100;
            4'hB: e_type = 3'b101;
            default: e_type = 3'b111;
        endcase
    endtask

    task automatic model_step;
        if (e_op == 4'h3) begin
            m_dmem[e_ins[7:0]] = m_r[e_rd];
            m_dv[e_ins[7:0]]   = 1'b1;
        end
        if (e_we) m_r[e_rd] = e_wd;
        if (e_op == 4'h0 || e_op == 4'h1) m_z = (e_res == 0);
        if (e_op == 4'h7 && m_stk.size() < 15) m_stk.push_back(m_pc + 19'd1);
        if (e_op == 4'h8 && m_stk.size() > 0) void'(m_stk.pop_back());
        m_pc = e_npc;
    endtask

    task automatic compare_all;
        chk("instruction", instruction_out, e_ins);
        chk("opcode", opcode_out, e_op);
        chk("rd", rd_out, e_rd);
        chk("rs1", rs1_out, e_rs1);
        chk("rs2", rs2_out, e_rs2);
        chk("alu_op", alu_op_out, e_aop);
        chk("alu_type", alu_type_out, e_type);
        chk("jump_addr", jump_addr_out, e_ins[10:0]);
        chk("branch_addr", branch_addr_out, e_ins[7:0]);
        chk("readdata1", readdata1_out, e_a);
        chk("readdata2", readdata2_out, e_b);
        chk("result", result_out, e_res);
        if (m_dv[e_ins[7:0]]) chk("mem_data", mem_data_out, m_dmem[e_ins[7:0]]);
        chk("write_data", write_data_out, e_wd);
        chk("pc", pc_out, m_pc);
        chk("pc_next", pc_next_out, e_npc);
        chk("sp", sp_out, m_stk.size());
        chk("encr_en", encr_en_out, e_op == 4'h9);
        chk("decr_en", decr_en_out, e_op == 4'hA);
        chk("encr_result", encr_result_out, e_crypto);
        chk("fft_en", fft_en_out, e_op == 4'hB);
        chk("fft_result", fft_result_out, e_fft);
    endtask

    task automatic literal_checks;
        case (m_pc)
            19'd2:  chk("lit_add", write_data_out, 19'd8);
            19'd3:  chk("lit_sub", write_data_out, 19'd0);
            19'd4:  chk("lit_bz_taken", pc_next_out, 19'd32);
            19'd5:  chk("lit_mul", write_data_out, 19'h006A9);
            19'd7:  chk("lit_call", pc_next_out, 19'd64);
            19'd8: begin
                chk("lit_ret_empty_sp", sp_out, 4'd0);
                chk("lit_ret_empty_pc", pc_next_out, 19'd9);
            end
            19'd10: chk("lit_shr19", write_data_out, 19'd0);
            19'd11: chk("lit_bnz_not", pc_next_out, 19'd12);
            19'd32: chk("lit_fft_add", write_data_out, 19'd8);
            19'd33: chk("lit_fft_sub", write_data_out, 19'd2);
            19'd36: chk("lit_enc", write_data_out, 19'h00D28);
            19'd37: chk("lit_dec", write_data_out, 19'h00155);
            19'd39: chk("lit_fft_wrap", write_data_out, 19'h7FFFF);
            19'd41: begin
                chk("lit_ld_mem", mem_data_out, 19'd5);
                chk("lit_ld_wd", write_data_out, 19'd5);
            end
            19'd42: chk("lit_div0", write_data_out, 19'h7FFFF);
            19'd48: if (m_stk.size() == 15) chk("lit_call_full", pc_next_out, 19'd49);
            19'd60: begin
                chk("lit_halt_pc", pc_next_out, 19'd60);
                chk("lit_halt_sp", sp_out, 4'd1);
            end
            19'd64: chk("lit_call_sp", sp_out, 4'd1);
            19'd65: chk("lit_ret", pc_next_out, 19'd8);
            default: ;
        endcase
    endtask

    // Runs from a fresh release until the program has sat at HALT for three cycles.
    task automatic run_program(output bit ok);
        int halts = 0;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            model_eval;
            compare_all;
            literal_checks;
            if (c < 3) chk("pc_after_release", pc_out, c);
            if (e_op == 4'hF) halts++;
            if (halts >= 3) begin
                ok = 1'b1;
                return;
            end
            model_step;
        end
        checks++;
        failures++;
        $display("FAIL halt_timeout actual=pc %0d required=HALT within 400 cycles", pc_out);
    endtask

    initial begin
        bit ok;
        load_program;
        model_reset;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_pc", pc_out, 19'd0);
        chk("rst_sp", sp_out, 4'd0);
        chk("rst_instr", instruction_out, m_prog[0]);
        chk("rst_rd1", readdata1_out, 19'd0);
        #1 reset = 1'b1;
        run_program(ok);
        if (ok) begin
            #2 reset = 1'b0;
            #1;
            chk("midrst_pc", pc_out, 19'd0);
            chk("midrst_sp", sp_out, 4'd0);
            chk("midrst_instr", instruction_out, m_prog[0]);
            model_reset;
            @(posedge clk);
            #2 reset = 1'b1;
            run_program(ok);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
